// File: rtl/xaddrgen_sched.sv
// xaddrgen_sched: job scheduler for one xaddrgen-class address generator.
//
// The host pushes packed addressing jobs into a 2^DEPTH_W-entry FIFO. When
// enabled, the scheduler pops one job into ag_cfg, pulses ag_init and then
// ag_run, and waits for the generator to report done before it considers
// the next job.
//
// Handshake: a job is accepted on a rising clk edge where cfg_valid and
// cfg_ready are both 1 and abort is 0. cfg_ready depends only on the
// registered fill level, never on cfg_valid.
//
// Ports:
//   clk, rst    clock; asynchronous active-low reset
//   en          1 = jobs may be launched; 0 = hold in IDLE (queue still fills)
//   abort       one-cycle pulse that flushes queued, not-yet-launched jobs
//   cfg_valid   job push request
//   cfg_ready   FIFO not full
//   cfg_data    packed job {iterations, period, duty, delay, start, shift, incr}
//   ag_init     one-cycle init pulse to the generator
//   ag_run      one-cycle run pulse to the generator
//   ag_cfg      configuration of the active job, same packing as cfg_data
//   ag_done     generator done (1 when idle)
//   busy        a job is launched and not yet complete
//   level       number of queued jobs, 0..2^DEPTH_W
//   job_cnt     completed jobs, wraps at 2^CNT_W
//   all_done    one-cycle pulse when a job completes with nothing queued
//   dbg_state   current FSM state (IDLE=0, LOAD=1, INIT=2, RUN=3, WAIT=4)
module xaddrgen_sched #(
  parameter int MEM_ADDR_W = 10,
  parameter int PERIOD_W   = 10,
  parameter int DEPTH_W    = 2,
  parameter int CNT_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 abort,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [4*PERIOD_W+3*MEM_ADDR_W-1:0]   cfg_data,
  output logic                                 ag_init,
  output logic                                 ag_run,
  output logic [4*PERIOD_W+3*MEM_ADDR_W-1:0]   ag_cfg,
  input  logic                                 ag_done,
  output logic                                 busy,
  output logic [DEPTH_W:0]                     level,
  output logic [CNT_W-1:0]                     job_cnt,
  output logic                                 all_done,
  output logic [2:0]                           dbg_state
);

  localparam int CFG_W = 4*PERIOD_W + 3*MEM_ADDR_W;
  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] FULL_LVL = (DEPTH_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_INIT = 3'd2,
    S_RUN  = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t state, state_n;

  logic [CFG_W-1:0]   mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_W:0]   level_n;
  logic               push, pop, complete;
  // Set from the second WAIT cycle on: the generator only drops done the
  // cycle after run, so done seen on the WAIT entry cycle is stale.
  logic               wait_arm;

  assign push     = cfg_valid && cfg_ready && !abort;
  assign pop      = (state == S_IDLE) && en && (level != '0) && !abort;
  assign complete = (state == S_WAIT) && wait_arm && ag_done;
  assign dbg_state = state;

  always_comb begin
    level_n = level;
    if (abort) begin
      level_n = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_n = level + 1'b1;
        2'b01:   level_n = level - 1'b1;
        default: level_n = level;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (pop) state_n = S_LOAD;
      S_LOAD:  state_n = S_INIT;
      S_INIT:  state_n = S_RUN;
      S_RUN:   state_n = S_WAIT;
      S_WAIT:  if (complete) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Storage is not reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cfg_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cfg_ready <= 1'b1;
      ag_cfg    <= '0;
      ag_init   <= 1'b0;
      ag_run    <= 1'b0;
      busy      <= 1'b0;
      job_cnt   <= '0;
      all_done  <= 1'b0;
      wait_arm  <= 1'b0;
    end else begin
      level     <= level_n;
      cfg_ready <= (level_n != FULL_LVL);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (abort) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        ag_cfg <= mem[rd_ptr];
      end
      ag_init  <= (state_n == S_INIT);
      ag_run   <= (state_n == S_RUN);
      wait_arm <= (state == S_WAIT) && (state_n == S_WAIT);
      if (pop)           busy <= 1'b1;
      else if (complete) busy <= 1'b0;
      if (complete) job_cnt <= job_cnt + 1'b1;
      // level_n already counts a same-cycle push and a same-cycle abort.
      all_done <= complete && (level_n == '0);
    end
  end

endmodule

// File: tb/tb_xaddrgen_sched.sv
// Directed testbench for xaddrgen_sched. A behavioural generator model drives
// ag_done; a scoreboard queue holds the configurations expected at each
// ag_init pulse. A second instance with a 2-bit job counter shares all
// inputs and is used for the counter wrap check.
module tb_xaddrgen_sched;
  localparam int AW    = 10;
  localparam int PW    = 10;
  localparam int DW    = 2;
  localparam int CW    = 16;
  localparam int CFG_W = 4*PW + 3*AW;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd4;

  logic             clk, rst, en, abort, cfg_valid;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_ready, ag_init, ag_run, busy, all_done, ag_done;
  logic [CFG_W-1:0] ag_cfg;
  logic [DW:0]      level;
  logic [CW-1:0]    job_cnt;
  logic [2:0]       dbg_state;

  logic             u2_cfg_ready, u2_ag_init, u2_ag_run, u2_busy, u2_all_done;
  logic [CFG_W-1:0] u2_ag_cfg;
  logic [DW:0]      u2_level;
  logic [1:0]       u2_job_cnt;
  logic [2:0]       u2_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int init_seen = 0;
  int done_seen = 0;
  int gen_len = 0;
  int gen_cnt;
  logic gen_done;
  logic [CFG_W-1:0] exp_q[$];

  xaddrgen_sched #(.MEM_ADDR_W(AW), .PERIOD_W(PW), .DEPTH_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .ag_init(ag_init), .ag_run(ag_run), .ag_cfg(ag_cfg), .ag_done(ag_done),
    .busy(busy), .level(level), .job_cnt(job_cnt), .all_done(all_done),
    .dbg_state(dbg_state)
  );

  xaddrgen_sched #(.MEM_ADDR_W(AW), .PERIOD_W(PW), .DEPTH_W(DW), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .en(en), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_ready(u2_cfg_ready), .cfg_data(cfg_data),
    .ag_init(u2_ag_init), .ag_run(u2_ag_run), .ag_cfg(u2_ag_cfg), .ag_done(ag_done),
    .busy(u2_busy), .level(u2_level), .job_cnt(u2_job_cnt), .all_done(u2_all_done),
    .dbg_state(u2_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator model: done falls the cycle after run, stays low for
  // gen_len+1 cycles, then rises.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      gen_done <= 1'b1;
      gen_cnt  <= 0;
    end else if (ag_run) begin
      gen_done <= 1'b0;
      gen_cnt  <= gen_len;
    end else if (!gen_done) begin
      if (gen_cnt == 0) gen_done <= 1'b1;
      else              gen_cnt  <= gen_cnt - 1;
    end
  end
  assign ag_done = gen_done;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every init pulse must present the next expected job.
  always @(negedge clk) begin
    if (rst && ag_init) begin
      init_seen++;
      if (exp_q.size() == 0) check_val("unexpected_init", 1, 0);
      else check_val("ag_cfg_at_init", ag_cfg, exp_q.pop_front());
    end
    if (rst && all_done) done_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CFG_W-1:0] make_job(input int iter, input int start);
    logic [PW-1:0] it;
    logic [AW-1:0] st;
    it = PW'(iter);
    st = AW'(start);
    return {it, 10'd4, 10'd4, 10'd0, st, 10'd0, 10'd1};
  endfunction

  task automatic push(input logic [CFG_W-1:0] d);
    cfg_valid = 1'b1;
    cfg_data  = d;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st);
    int n = 0;
    while (dbg_state != st && n < 200) begin step(); n++; end
    if (dbg_state != st) check_val("timeout_state", dbg_state, st);
  endtask

  task automatic wait_busy_low(output int n);
    n = 0;
    while (busy && n < 200) begin step(); n++; end
    if (busy) check_val("timeout_busy", busy, 0);
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (job_cnt != CW'(target) && n < 400) begin step(); n++; end
    if (job_cnt != CW'(target)) check_val("timeout_cnt", job_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, d0, i0;
    rst = 1'b0; en = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    step(); step();
    check_val("rst_state", dbg_state, ST_IDLE);
    check_val("rst_level", level, 0);
    check_val("rst_ready", cfg_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_cfg", ag_cfg, 0);
    check_val("rst_pulses", {ag_init, ag_run, all_done}, 0);
    check_val("rst_cnt", job_cnt, 0);
    rst = 1'b1;
    step();

    // Single job with the reference configuration.
    en = 1'b1; gen_len = 7;
    exp_q.push_back({10'd2, 10'd4, 10'd4, 10'd0, 10'd5, 10'd0, 10'd1});
    push({10'd2, 10'd4, 10'd4, 10'd0, 10'd5, 10'd0, 10'd1});
    check_val("t1_level_after_push", level, 1);
    check_val("t1_idle_after_push", dbg_state, ST_IDLE);
    step();
    check_val("t1_load", dbg_state, ST_LOAD);
    check_val("t1_busy_load", busy, 1);
    check_val("t1_init_not_yet", ag_init, 0);
    step();
    check_val("t1_init_pop_plus2", ag_init, 1);
    step();
    check_val("t1_run_pop_plus3", {ag_init, ag_run}, 2'b01);
    wait_busy_low(lat);
    check_val("t1_done_latency", lat, 10);
    check_val("t1_all_done", all_done, 1);
    check_val("t1_cnt", job_cnt, 1);
    step();
    check_val("t1_all_done_one_cycle", all_done, 0);

    // Fill with en=0, fifth push must be dropped.
    en = 1'b0; gen_len = 2;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(make_job(i + 3, i));
      push(make_job(i + 3, i));
    end
    check_val("t2_level_full", level, 4);
    check_val("t2_ready_low", cfg_ready, 0);
    d0 = done_seen; i0 = init_seen;
    en = 1'b1;
    wait_cnt(5);
    step();
    check_val("t2_inits", init_seen - i0, 4);
    check_val("t2_one_all_done", done_seen - d0, 1);
    check_val("t2_queue_drained", exp_q.size(), 0);
    check_val("t2_ready_back", cfg_ready, 1);

    // Abort during WAIT of the first of three jobs.
    en = 1'b0; gen_len = 5;
    exp_q.push_back(make_job(1, 10));
    push(make_job(1, 10));
    push(make_job(1, 11));
    push(make_job(1, 12));
    d0 = done_seen; i0 = init_seen;
    en = 1'b1;
    wait_state(ST_WAIT);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_val("t3_level_flushed", level, 0);
    check_val("t3_busy_kept", busy, 1);
    wait_busy_low(lat);
    check_val("t3_all_done", all_done, 1);
    check_val("t3_cnt", job_cnt, 6);
    repeat (10) step();
    check_val("t3_no_more_init", init_seen - i0, 1);
    check_val("t3_done_pulses", done_seen - d0, 1);

    // Push during the last job's WAIT suppresses all_done.
    gen_len = 4;
    exp_q.push_back(make_job(2, 20));
    push(make_job(2, 20));
    wait_state(ST_WAIT);
    exp_q.push_back(make_job(2, 21));
    push(make_job(2, 21));
    check_val("t4_level_one", level, 1);
    wait_busy_low(lat);
    check_val("t4_no_all_done", all_done, 0);
    check_val("t4_idle_gap", dbg_state, ST_IDLE);
    step();
    check_val("t4_load_next", {busy, dbg_state}, {1'b1, ST_LOAD});
    step();
    check_val("t4_init_next", ag_init, 1);
    wait_busy_low(lat);
    check_val("t4_all_done_last", all_done, 1);
    check_val("t4_cnt", job_cnt, 8);

    // Asynchronous reset in the middle of WAIT with a job still queued.
    gen_len = 20;
    exp_q.push_back(make_job(3, 30));
    push(make_job(3, 30));
    wait_state(ST_WAIT);
    push(make_job(3, 31));
    #2 rst = 1'b0;
    #1;
    check_val("t5_async_busy", busy, 0);
    check_val("t5_async_level", level, 0);
    check_val("t5_async_cnt", job_cnt, 0);
    check_val("t5_async_state", dbg_state, ST_IDLE);
    check_val("t5_async_cfg", ag_cfg, 0);
    check_val("t5_async_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b1;
    cfg_data  = make_job(3, 32);
    exp_q.push_back(make_job(3, 32));
    gen_len = 0;
    #2 rst = 1'b1;
    step();
    cfg_valid = 1'b0;
    check_val("t5_rel_c1_level", level, 1);
    check_val("t5_rel_c1_init", ag_init, 0);
    step();
    check_val("t5_rel_c2_init", ag_init, 0);
    step();
    check_val("t5_rel_c3_init", ag_init, 1);
    wait_busy_low(lat);
    check_val("t5_cnt", job_cnt, 1);

    // Counter wrap on the 2-bit instance after five short jobs.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    d0 = done_seen;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(make_job(4, 40 + i));
      push(make_job(4, 40 + i));
      wait_cnt(i + 1);
    end
    step();
    check_val("t6_cnt16", job_cnt, 5);
    check_val("t6_cnt2_wrap", u2_job_cnt, 1);
    check_val("t6_all_done_each", done_seen - d0, 5);
    check_val("t6_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
